// File: rtl/vga_timing.sv
// VGA raster timing generator fed from a show-ahead pixel FIFO.
// Waits for the FIFO to prime, then free-runs; outputs are registered one cycle after the counters.
module vga_timing #(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned HFP    = 40,
    parameter int unsigned HPULSE = 48,
    parameter int unsigned HBP    = 40,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned VFP    = 13,
    parameter int unsigned VPULSE = 3,
    parameter int unsigned VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    input  logic        fifo_almost_full,
    output logic        fifo_rd,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int unsigned VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] HMax       = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] HSyncStart = HW'(HFP);
    localparam logic [HW-1:0] HSyncEnd   = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] HActStart  = HW'(HTOTAL - HDISP);
    localparam logic [VW-1:0] VMax       = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] VSyncStart = VW'(VFP);
    localparam logic [VW-1:0] VSyncEnd   = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] VActStart  = VW'(VTOTAL - VDISP);

    typedef enum logic [0:0] {StWaitFifo, StRun} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, uf_q, uf_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          run, active, h_pulse, v_pulse;

    // State register
    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) state_q <= StWaitFifo;
        else              state_q <= state_d;
    end

    // Next state: RUN is terminal until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitFifo: if (fifo_almost_full) state_d = StRun;
            StRun:      state_d = StRun;
            default:    state_d = StWaitFifo;
        endcase
    end

    // Output decode
    always_comb begin
        run     = (state_q == StRun);
        active  = (hcnt_q >= HActStart) && (vcnt_q >= VActStart);
        h_pulse = (hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd);
        v_pulse = (vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd);
        fifo_rd = run && active && !fifo_empty;
    end

    always_comb begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (run) begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
            if (hcnt_q == HMax) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VMax) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hs_d  = !(run && h_pulse);
        vs_d  = !(run && v_pulse);
        de_d  = run && active;
        rgb_d = fifo_rd ? fifo_rdata : 24'h000000;
        fs_d  = run && (hcnt_q == HActStart) && (vcnt_q == VActStart);
        uf_d  = uf_q || (run && active && fifo_empty);
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            rgb_q  <= 24'h000000;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            rgb_q  <= rgb_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
        end
    end

    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign video_rgb   = rgb_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule
